// File: rtl/mux_sweep_pkg.sv
// mux_sweep_pkg: shared state encodings, sizes and golden table for the mux truth-table sweeper
package mux_sweep_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;
    localparam int IDX_W = 4;
    localparam int NUM_VEC = 16;
    localparam logic [NUM_VEC-1:0] MUX_FN_GOLDEN = 16'hE3BB;
    function automatic logic [IDX_W-1:0] lowest_diff(input logic [NUM_VEC-1:0] a, input logic [NUM_VEC-1:0] b);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--)
            if (a[i] != b[i]) res = IDX_W'(i);
        return res;
    endfunction
endpackage

// File: rtl/mux_sweep_timer.sv
// mux_sweep_timer: 8-bit loadable down-counter with zero flag
// Ports: clk, rst (async active-high), load/load_val (reload), dec (count down), zero (count is 0)
module mux_sweep_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [7:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (load) r_cnt <= load_val;
        else if (dec && !zero) r_cnt <= r_cnt - 8'd1;
    assign zero = (r_cnt == 8'd0);
endmodule

// File: rtl/mux_truth_table_sweeper.sv
// mux_truth_table_sweeper: steps 16 {s0,s1,s2,d} vectors into a mux-function block and packs y into a table
// Ports: clk, rst (async active-high), start, y_in; outputs d/s0/s1/s2 (vector), busy, done, table_out
// Optional: MUX_SWEEP_COMPARE_EN adds pass/fail_idx against EXPECTED
module mux_truth_table_sweeper
    import mux_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0
`ifdef MUX_SWEEP_COMPARE_EN
    , parameter logic [NUM_VEC-1:0] EXPECTED = MUX_FN_GOLDEN
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               y_in,
    output logic               d,
    output logic               s0,
    output logic               s1,
    output logic               s2,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] table_out
`ifdef MUX_SWEEP_COMPARE_EN
    , output logic             pass,
    output logic [IDX_W-1:0]   fail_idx
`endif
);
    state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [NUM_VEC-1:0] r_table;
    logic r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic w_zero, w_accept, w_last, w_load;
    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last = (r_idx == IDX_W'(NUM_VEC - 1));
    assign w_load = w_accept || (r_state == ST_CAPTURE && !w_last);
    mux_sweep_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (8'(SETTLE_CYCLES)),
        .dec      (r_state == ST_SETTLE),
        .zero     (w_zero)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_next = start ? ST_SETTLE : r_state;
            ST_SETTLE:        w_next = w_zero ? ST_CAPTURE : ST_SETTLE;
            ST_CAPTURE:       w_next = w_last ? ST_DONE : ST_SETTLE;
            default:          w_next = ST_IDLE;
        endcase
    end
    always_comb begin
        w_busy_nxt = (w_next == ST_SETTLE) || (w_next == ST_CAPTURE);
        w_done_nxt = (w_next == ST_DONE);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_idx   <= '0;
            r_table <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_idx   <= '0;
                r_table <= '0;
            end else if (r_state == ST_CAPTURE) begin
                r_table[r_idx] <= y_in;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
        end
`ifdef MUX_SWEEP_COMPARE_EN
    logic r_pass;
    logic [IDX_W-1:0] r_fail_idx;
    logic [NUM_VEC-1:0] w_final;
    // the last bit is still in flight on the DONE-entry edge, so splice it in
    assign w_final = {y_in, r_table[NUM_VEC-2:0]};
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (w_accept) begin
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (r_state == ST_CAPTURE && w_last) begin
            r_pass     <= (w_final == EXPECTED);
            r_fail_idx <= lowest_diff(w_final, EXPECTED);
        end
    assign pass = r_pass;
    assign fail_idx = r_fail_idx;
`endif
    assign d = r_idx[0];
    assign s0 = r_idx[3];
    assign s1 = r_idx[2];
    assign s2 = r_idx[1];
    assign busy = r_busy;
    assign done = r_done;
    assign table_out = r_table;
endmodule

// File: tb/tb_mux_truth_table_sweeper.sv
// tb_mux_truth_table_sweeper: self-checking bench for mux_truth_table_sweeper
module tb_mux_truth_table_sweeper;
    typedef struct {
        bit          sel3;
        logic [15:0] fn;
        int          busy_at;
        logic [15:0] exp_tab;
        int          exp_lat;
    } vec_t;
    localparam logic [15:0] GOLD = 16'hE3BB;
    logic clk = 1'b0, rst = 1'b1, r_start = 1'b0, sel = 1'b0;
    logic [15:0] fn0 = 16'h0, fn3 = 16'h0;
    logic d0, a0, b0, c0, busy0, done0, d3, a3, b3, c3, busy3, done3;
    logic [15:0] tab0, tab3;
    logic [3:0] vec0, vec3, cvec;
    logic y0, y3, cdone, cbusy;
    logic [15:0] ctab;
    int n_tests = 0, n_fail = 0;
    vec_t rows[10];
`ifdef MUX_SWEEP_COMPARE_EN
    logic pass0, pass3;
    logic [3:0] fidx0, fidx3;
`endif
    always #5 clk = ~clk;
    assign vec0 = {a0, b0, c0, d0};
    assign vec3 = {a3, b3, c3, d3};
    assign y0 = fn0[vec0];
    assign y3 = fn3[vec3];
    assign cvec = sel ? vec3 : vec0;
    assign cdone = sel ? done3 : done0;
    assign cbusy = sel ? busy3 : busy0;
    assign ctab = sel ? tab3 : tab0;
    mux_truth_table_sweeper #(.SETTLE_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .start(r_start && !sel), .y_in(y0),
        .d(d0), .s0(a0), .s1(b0), .s2(c0), .busy(busy0), .done(done0), .table_out(tab0)
`ifdef MUX_SWEEP_COMPARE_EN
        , .pass(pass0), .fail_idx(fidx0)
`endif
    );
    mux_truth_table_sweeper #(.SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(r_start && sel), .y_in(y3),
        .d(d3), .s0(a3), .s1(b3), .s2(c3), .busy(busy3), .done(done3), .table_out(tab3)
`ifdef MUX_SWEEP_COMPARE_EN
        , .pass(pass3), .fail_idx(fidx3)
`endif
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int lat_of(input bit s3);
        return 16 * ((s3 ? 3 : 0) + 2);
    endfunction
    function automatic logic [3:0] first_diff(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        int i;
        x = a ^ b;
        i = 0;
        while (i < 15 && !x[i]) i++;
        return x[i] ? 4'(i) : 4'd0;
    endfunction
    task automatic run(input vec_t r);
        int k, sc, order_err;
        bit pulsed;
        sel = r.sel3;
        if (r.sel3) fn3 = r.fn;
        else fn0 = r.fn;
        sc = r.sel3 ? 3 : 0;
        @(negedge clk);
        r_start = 1'b1;
        @(posedge clk);
        #1 r_start = 1'b0;
        check("clear_on_accept", {15'd0, cdone, ctab}, 32'd0);
        k = 0;
        order_err = 0;
        pulsed = 0;
        while (!cdone && k < 1000) begin
            if (cvec != 4'(k / (sc + 2)) || !cbusy) order_err++;
            if (r.busy_at >= 0 && !pulsed && int'(cvec) == r.busy_at) begin
                r_start = 1'b1;
                pulsed = 1;
            end
            @(posedge clk);
            #1 r_start = 1'b0;
            k++;
        end
        check("latency", k, r.exp_lat);
        check("table", {16'd0, ctab}, {16'd0, r.exp_tab});
        check("vector_order", order_err, 0);
        check("busy_low_in_done", {31'd0, cbusy}, 32'd0);
`ifdef MUX_SWEEP_COMPARE_EN
        check("pass", {31'd0, sel ? pass3 : pass0}, {31'd0, r.exp_tab == GOLD});
        check("fail_idx", {28'd0, sel ? fidx3 : fidx0}, {28'd0, first_diff(r.exp_tab, GOLD)});
`endif
    endtask
    initial begin
        int k;
        logic [15:0] f;
        rows[0] = '{0, GOLD, -1, 16'hE3BB, 32};
        rows[1] = '{0, 16'hFFFF, -1, 16'hFFFF, 32};
        rows[2] = '{1, GOLD, -1, 16'hE3BB, 80};
        rows[3] = '{0, GOLD, 5, 16'hE3BB, 32};
        rows[4] = '{0, GOLD, -1, 16'hE3BB, 32};
        for (int i = 5; i < 10; i++) begin
            f = 16'($urandom);
            rows[i].sel3 = 1'($urandom_range(0, 1));
            rows[i].fn = f;
            rows[i].busy_at = (i == 7) ? 9 : -1;
            rows[i].exp_tab = f;
            rows[i].exp_lat = lat_of(rows[i].sel3);
        end
        repeat (3) @(posedge clk);
        #1 check("reset_state_u0", {9'd0, d0, a0, b0, c0, busy0, done0, tab0}, 32'd0);
        check("reset_state_u3", {9'd0, d3, a3, b3, c3, busy3, done3, tab3}, 32'd0);
        @(negedge clk) rst = 1'b0;
        sel = 1'b0;
        fn0 = GOLD;
        @(negedge clk) r_start = 1'b1;
        @(negedge clk) r_start = 1'b0;
        k = 0;
        while (vec0 != 4'd7 && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        check("reach_idx7", {28'd0, vec0}, 32'd7);
        #2 rst = 1'b1;
        #1 check("async_reset_mid_sweep", {9'd0, d0, a0, b0, c0, busy0, done0, tab0}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(posedge clk);
        #1 check("no_done_after_reset", {15'd0, done0, tab0}, 32'd0);
        foreach (rows[i]) run(rows[i]);
        repeat (5) @(posedge clk);
        #1 check("table_stable_in_done", {16'd0, ctab}, {16'd0, rows[9].exp_tab});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
